// File: rtl/dmem_ctrl.sv
// Single-port data memory controller with a three-state
// request/response FSM, byte-enable writes and address checks.
module dmem_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h6800_0000
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                REQ,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [31:0]         A,
  input  logic [DATA_W-1:0]   WD,
  output logic                READY,
  output logic                RVALID,
  output logic [DATA_W-1:0]   RD,
  output logic                ERR
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SPAN  = DEPTH * NB;

  localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
  localparam logic [32:0] LAST33 = BASE33 + 33'(SPAN) - 33'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q;
  logic              ready_q;
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_q;

  logic              we_q;
  logic [NB-1:0]     be_q;
  logic [31:0]       a_q;
  logic [DATA_W-1:0] wd_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [32:0]      a33;
  logic [32:0]      off;
  logic [IDX_W-1:0] idx;
  logic             in_rng;
  logic             mis;
  logic             bad;
  logic             wr_en;

  // 33-bit compare keeps addresses near the top of the map from wrapping
  always_comb begin
    a33    = {1'b0, a_q};
    off    = a33 - BASE33;
    idx    = IDX_W'(off >> OFF_W);
    in_rng = (a33 >= BASE33) && (a33 <= LAST33);
  end

  if (OFF_W > 0) begin : g_mis
    assign mis = |a_q[OFF_W-1:0];
  end else begin : g_nomis
    assign mis = 1'b0;
  end

  assign bad   = !in_rng || mis;
  assign wr_en = (state_q == ACCESS) && we_q && !bad;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      a_q      <= '0;
      wd_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rd_q     <= '0;
          if (REQ) begin
            we_q    <= WE;
            be_q    <= BE;
            a_q     <= A;
            wd_q    <= WD;
            ready_q <= 1'b0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rvalid_q <= 1'b1;
          err_q    <= bad;
          rd_q     <= (we_q || bad) ? '0 : mem_q[idx];
          state_q  <= RESP;
        end
        RESP: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rd_q     <= '0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rd_q     <= '0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Array is deliberately not reset; async reset clears state_q, so
  // a write pending in ACCESS never reaches this block.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) begin
          mem_q[idx][i*8 +: 8] <= wd_q[i*8 +: 8];
        end
      end
    end
  end

  assign READY  = ready_q;
  assign RVALID = rvalid_q;
  assign RD     = rd_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table, hand-written
// corner sequences and a randomized run against a byte-level model.
module tb_dmem_ctrl;

  localparam logic [31:0] BASE = 32'h6800_0000;

  logic clk;
  logic rst_n;

  logic        req, we;
  logic [3:0]  be;
  logic [31:0] a, wd;
  logic        ready, rvalid, err;
  logic [31:0] rd;

  logic        req64, we64;
  logic [7:0]  be64;
  logic [31:0] a64;
  logic [63:0] wd64;
  logic        ready64, rvalid64, err64;
  logic [63:0] rd64;

  bit          sel;
  logic        m_ready, m_rvalid, m_err;
  logic [63:0] m_rd;

  int total = 0;
  int bad = 0;

  logic [31:0] mm [256];
  bit   [3:0]  known [256];

  dmem_ctrl u_dut (
    .CLK(clk), .RSTn(rst_n), .REQ(req), .WE(we), .BE(be),
    .A(a), .WD(wd), .READY(ready), .RVALID(rvalid),
    .RD(rd), .ERR(err)
  );

  dmem_ctrl #(.DATA_W(64), .DEPTH(16)) u_dut64 (
    .CLK(clk), .RSTn(rst_n), .REQ(req64), .WE(we64), .BE(be64),
    .A(a64), .WD(wd64), .READY(ready64), .RVALID(rvalid64),
    .RD(rd64), .ERR(err64)
  );

  always_comb begin
    m_ready  = sel ? ready64  : ready;
    m_rvalid = sel ? rvalid64 : rvalid;
    m_err    = sel ? err64    : err;
    m_rd     = sel ? rd64     : {32'h0, rd};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [7:0] b,
                       input logic [31:0] ad, input logic [63:0] d);
    if (sel) begin
      req64 = r; we64 = w; be64 = b; a64 = ad; wd64 = d;
    end else begin
      req = r; we = w; be = b[3:0]; a = ad; wd = d[31:0];
    end
  endtask

  function automatic bit mdl_err(input logic [31:0] ad);
    longint off;
    off = longint'(ad) - longint'(BASE);
    return !(off >= 0 && off < 1024) || (ad % 4 != 0);
  endfunction

  function automatic int mdl_idx(input logic [31:0] ad);
    return int'((longint'(ad) - longint'(BASE)) / 4);
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!m_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", m_ready, 1);
  endtask

  task automatic txn(input bit w, input logic [7:0] b,
                     input logic [31:0] ad, input logic [63:0] d,
                     output logic [63:0] rdo, output logic erro);
    wait_ready();
    drive(1, w, b, ad, d);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("access_rvalid", m_rvalid, 0);
    chk("access_ready", m_ready, 0);
    @(negedge clk);
    chk("resp_rvalid", m_rvalid, 1);
    chk("resp_ready", m_ready, 0);
    rdo  = m_rd;
    erro = m_err;
    @(negedge clk);
    chk("idle_rvalid", m_rvalid, 0);
    chk("idle_rd", m_rd, 0);
    chk("idle_err", m_err, 0);
    chk("idle_ready", m_ready, 1);
    if (!sel && w && !mdl_err(ad)) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) begin
          mm[mdl_idx(ad)][i*8 +: 8] = d[i*8 +: 8];
          known[mdl_idx(ad)][i] = 1'b1;
        end
      end
    end
  endtask

  task automatic rst_mid(input logic [31:0] ad, input logic [63:0] d,
                         input logic [63:0] old);
    logic [63:0] r;
    logic        e;
    wait_ready();
    drive(1, 1, 8'hFF, ad, d);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", m_ready, 1);
    chk("rst_rvalid", m_rvalid, 0);
    @(posedge clk);
    #1 chk("rst_hold_rvalid", m_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_rvalid", m_rvalid, 0);
    txn(0, 0, ad, 0, r, e);
    chk("rst_old_err", {63'h0, e}, 0);
    chk("rst_old_rd", r, old);
  endtask

  typedef struct {
    bit          w;
    logic [3:0]  b;
    logic [31:0] ad;
    logic [31:0] d;
    bit          e;
    logic [31:0] r;
    bit          cr;
  } vec_t;

  vec_t tbl [22];

  initial begin
    logic [63:0] r;
    logic        e;
    int          acc, pulses, lat;

    tbl[0]  = '{1, 4'hF, 32'h6800_0010, 32'hDEAD_BEEF, 0, 0, 1};
    tbl[1]  = '{0, 4'h0, 32'h6800_0010, 0, 0, 32'hDEAD_BEEF, 1};
    tbl[2]  = '{1, 4'hF, 32'h6800_0020, 32'h1122_3344, 0, 0, 1};
    tbl[3]  = '{1, 4'h5, 32'h6800_0020, 32'hAABB_CCDD, 0, 0, 1};
    tbl[4]  = '{0, 4'h0, 32'h6800_0020, 0, 0, 32'h11BB_33DD, 1};
    tbl[5]  = '{1, 4'hF, 32'h6800_0030, 32'hCAFE_F00D, 0, 0, 1};
    tbl[6]  = '{1, 4'h0, 32'h6800_0030, 32'h1234_5678, 0, 0, 1};
    tbl[7]  = '{0, 4'h0, 32'h6800_0030, 0, 0, 32'hCAFE_F00D, 1};
    tbl[8]  = '{1, 4'hF, 32'h6800_03FC, 32'h0BAD_0BAD, 0, 0, 1};
    tbl[9]  = '{0, 4'h0, 32'h6800_03FC, 0, 0, 32'h0BAD_0BAD, 1};
    tbl[10] = '{1, 4'hF, 32'h6800_0000, 32'h00C0_FFEE, 0, 0, 1};
    tbl[11] = '{0, 4'h0, 32'h6800_0000, 0, 0, 32'h00C0_FFEE, 1};
    tbl[12] = '{0, 4'h0, 32'h6800_0400, 0, 1, 0, 1};
    tbl[13] = '{0, 4'h0, 32'h67FF_FFFC, 0, 1, 0, 1};
    tbl[14] = '{0, 4'h0, 32'hFFFF_FFFC, 0, 1, 0, 1};
    tbl[15] = '{1, 4'hF, 32'h6800_0400, 32'h5555_5555, 1, 0, 1};
    tbl[16] = '{1, 4'hF, 32'h67FF_FFFC, 32'h6666_6666, 1, 0, 1};
    tbl[17] = '{1, 4'hF, 32'hFFFF_FFFC, 32'h7777_7777, 1, 0, 1};
    tbl[18] = '{1, 4'hF, 32'h6800_0002, 32'hFFFF_FFFF, 1, 0, 1};
    tbl[19] = '{0, 4'h0, 32'h6800_0000, 0, 0, 32'h00C0_FFEE, 1};
    tbl[20] = '{0, 4'h0, 32'h6800_03FC, 0, 0, 32'h0BAD_0BAD, 1};
    tbl[21] = '{0, 4'h0, 32'h6800_0003, 0, 1, 0, 1};

    foreach (known[i]) known[i] = '0;
    sel = 0;
    req = 0; we = 0; be = 0; a = 0; wd = 0;
    req64 = 0; we64 = 0; be64 = 0; a64 = 0; wd64 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rd", rd, 0);
    chk("reset_err", err, 0);
    chk("reset_ready64", ready64, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      txn(tbl[i].w, {4'h0, tbl[i].b}, tbl[i].ad, {32'h0, tbl[i].d}, r, e);
      chk($sformatf("vec%0d_err", i), {63'h0, e}, {63'h0, tbl[i].e});
      if (tbl[i].cr) chk($sformatf("vec%0d_rd", i), r, {32'h0, tbl[i].r});
    end

    // back-to-back: REQ held for 9 edges
    @(negedge clk);
    drive(1, 0, 0, 32'h6800_0010, 0);
    acc = 0;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b_ready%0d", i), ready, (i % 3 == 0));
      chk($sformatf("b2b_rvalid%0d", i), rvalid, (i % 3 == 2));
      if (rvalid) begin
        pulses++;
        chk("b2b_rd", rd, 32'hDEAD_BEEF);
      end
      @(posedge clk);
      if (ready) acc++;
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
    chk("b2b_accepts", acc, 3);
    chk("b2b_pulses", pulses, 3);

    rst_mid(32'h6800_0010, 64'h0000_0000_1357_9BDF, 64'h0000_0000_DEAD_BEEF);

    // reset while the response is on the bus
    wait_ready();
    drive(1, 0, 0, 32'h6800_0010, 0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rresp_rvalid_pre", rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rresp_rvalid", rvalid, 0);
    chk("rresp_rd", rd, 0);
    chk("rresp_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    sel = 1;
    txn(1, 8'hFF, 32'h6800_0018, 64'h0123_4567_89AB_CDEF, r, e);
    chk("w64_err", {63'h0, e}, 0);
    txn(0, 8'h00, 32'h6800_0018, 0, r, e);
    chk("r64_rd", r, 64'h0123_4567_89AB_CDEF);
    txn(1, 8'h0F, 32'h6800_001C, 64'hFFFF_FFFF_FFFF_FFFF, r, e);
    chk("w64_mis_err", {63'h0, e}, 1);
    txn(0, 8'h00, 32'h6800_0080, 0, r, e);
    chk("r64_oor_err", {63'h0, e}, 1);
    chk("r64_oor_rd", r, 0);
    rst_mid(32'h6800_0018, 64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF);
    sel = 0;

    for (int n = 0; n < 200; n++) begin
      logic [31:0] ad, d, msk, expr;
      bit          w;
      logic [3:0]  b;
      int          k;
      int          sel_a;
      sel_a = $urandom_range(0, 9);
      if (sel_a < 7) ad = BASE + 32'($urandom_range(0, 255)) * 4;
      else if (sel_a == 7) ad = BASE + 32'($urandom_range(0, 1023));
      else if (sel_a == 8) ad = BASE + 32'h400 + 32'($urandom_range(0, 64)) * 4;
      else ad = $urandom;
      w = $urandom_range(0, 1) == 1;
      b = 4'($urandom);
      d = $urandom;
      expr = 0;
      msk = 0;
      if (!w && !mdl_err(ad)) begin
        k = mdl_idx(ad);
        for (int i = 0; i < 4; i++) if (known[k][i]) msk[i*8 +: 8] = 8'hFF;
        expr = mm[k] & msk;
      end
      txn(w, {4'h0, b}, ad, {32'h0, d}, r, e);
      chk($sformatf("rnd%0d_err", n), {63'h0, e}, {63'h0, mdl_err(ad)});
      if (w || mdl_err(ad)) chk($sformatf("rnd%0d_rd0", n), r, 0);
      else chk($sformatf("rnd%0d_rd", n), r[31:0] & msk, {32'h0, expr});
    end

    lat = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
